// File: rtl/load_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// load_port_arbiter_pkg
//   Shared types and helpers for the load-port arbiter.
//   - LD_UOp      : load micro-op as seen by the LSU load pipeline
//   - PW_LD_UOp   : reduced load request issued by external sources
//                   (page walker, prefetcher, ...)
//   - LD_SRC_AGU  : source code reported for AGU-originated slot contents
//   - SRC_W       : source-field width for the default external count
//   - convertExtLd: expands an external request into a full LD_UOp
// ---------------------------------------------------------------------------
package load_port_arbiter_pkg;

  localparam int NUM_AGUS    = 2;
  localparam int DEF_NUM_EXT = 2;
  localparam int LD_SRC_AGU  = 0;
  localparam int SRC_W       = $clog2(DEF_NUM_EXT + 1);

  // Tag value meaning "no destination register"
  localparam logic [6:0] TAG_ZERO = 7'h40;

  typedef struct packed {
    logic [31:0] data;
    logic        dataValid;
    logic [31:0] addr;
    logic        signExtend;
    logic [1:0]  size;
    logic [6:0]  sqN;
    logic [6:0]  tagDst;
    logic [6:0]  loadSqN;
    logic [6:0]  storeSqN;
    logic        doNotCommit;
    logic        atomic;
    logic        external;
    logic        isMMIO;
    logic        valid;
  } LD_UOp;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } PW_LD_UOp;

  // External loads are always word-sized, never commit and carry no
  // destination tag; the data field is a don't-care until the load returns.
  function automatic LD_UOp convertExtLd(input PW_LD_UOp ext);
    LD_UOp uop;
    uop             = '0;
    uop.data        = 'x;
    uop.dataValid   = 1'b0;
    uop.addr        = ext.addr;
    uop.signExtend  = 1'b0;
    uop.size        = 2'd2;
    uop.sqN         = '0;
    uop.tagDst      = TAG_ZERO;
    uop.loadSqN     = '0;
    uop.storeSqN    = '0;
    uop.doNotCommit = 1'b1;
    uop.atomic      = 1'b0;
    uop.external    = 1'b1;
    uop.isMMIO      = 1'b0;
    uop.valid       = 1'b1;
    return uop;
  endfunction

endpackage

// File: rtl/load_port_arb_slot.sv
// ---------------------------------------------------------------------------
// load_port_arb_slot
//   One load port: picks between the AGU and NUM_EXT external sources,
//   keeps an AGU starvation age counter and a round-robin pointer, and
//   holds the winner in a single registered output slot.
// Ports
//   clk, rst      clock, async active-high reset
//   flush         kills the incoming AGU request and an AGU op in the slot
//   aguLd         AGU request;           aguLdStall  : AGU must hold
//   extLd[k]      external requests;     extLdStall  : ext k must hold
//   ldUOpStall    pipeline back-pressure on the slot
//   ldUOp, ldSrc  slot contents and their source (0=AGU, k+1=ext k)
// ---------------------------------------------------------------------------
module load_port_arb_slot
  import load_port_arbiter_pkg::*;
#(
  parameter int NUM_EXT    = 2,
  parameter int RR_EXT     = 1,
  parameter int STARVE_LIM = 7,
  localparam int SRC_BITS  = $clog2(NUM_EXT + 1),
  localparam int PTR_W     = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  LD_UOp               aguLd,
  output logic                aguLdStall,
  input  PW_LD_UOp            extLd [NUM_EXT],
  output logic [NUM_EXT-1:0]  extLdStall,
  input  logic                ldUOpStall,
  output LD_UOp               ldUOp,
  output logic [SRC_BITS-1:0] ldSrc
);

  logic             ldEn;
  logic             aguOk;
  logic             extAny;
  logic [PTR_W-1:0] extPick;
  logic             aguWin;
  logic             extGrant;
  logic [PTR_W-1:0] rrPtr;
  logic [3:0]       age;

  // The slot can take a new op when it is empty or being drained this cycle.
  // A flushed AGU request is treated as absent.
  assign ldEn  = !ldUOp.valid || !ldUOpStall;
  assign aguOk = aguLd.valid && !flush;

  // Candidate external source: first valid one scanning from the round-robin
  // pointer, or from index 0 when fixed priority is configured.
  always_comb begin
    int idx;
    extAny  = 1'b0;
    extPick = '0;
    idx     = 0;
    for (int i = 0; i < NUM_EXT; i++) begin
      idx = (RR_EXT != 0) ? ((int'(rrPtr) + i) % NUM_EXT) : i;
      if (!extAny && extLd[PTR_W'(idx)].valid) begin
        extAny  = 1'b1;
        extPick = PTR_W'(idx);
      end
    end
  end

  // Winner selection: a starved AGU overrides the external sources, otherwise
  // external traffic has priority and the AGU gets the leftover cycles.
  // Everything valid that did not win is told to hold; a flushed AGU request
  // is dropped rather than stalled.
  always_comb begin
    aguWin     = 1'b0;
    extGrant   = 1'b0;
    extLdStall = '0;
    if (ldEn) begin
      if (age == 4'(STARVE_LIM) && aguOk) begin
        aguWin = 1'b1;
      end else if (extAny) begin
        extGrant = 1'b1;
      end else if (aguOk) begin
        aguWin = 1'b1;
      end
    end
    aguLdStall = aguOk && !aguWin;
    for (int k = 0; k < NUM_EXT; k++) begin
      extLdStall[k] = extLd[k].valid && !(extGrant && extPick == PTR_W'(k));
    end
  end

  // Age counts how often a waiting AGU op lost to external traffic. Losing
  // because the pipeline is stalled does not count, since nobody won then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (flush || aguWin) begin
      age <= '0;
    end else if (extGrant && aguLd.valid && age < 4'(STARVE_LIM)) begin
      age <= age + 4'd1;
    end
  end

  // Round-robin pointer moves just past the external source that was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= '0;
    end else if (extGrant) begin
      rrPtr <= (extPick == PTR_W'(NUM_EXT - 1)) ? '0 : extPick + PTR_W'(1);
    end
  end

  // Output slot: load the winner when enabled, otherwise hold. A flush only
  // removes AGU ops; external ops are not speculative and must survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldUOp <= '0;
      ldSrc <= '0;
    end else if (ldEn) begin
      if (aguWin) begin
        ldUOp <= aguLd;
        ldSrc <= SRC_BITS'(LD_SRC_AGU);
      end else if (extGrant) begin
        ldUOp <= convertExtLd(extLd[extPick]);
        ldSrc <= SRC_BITS'(extPick) + SRC_BITS'(1);
      end else begin
        ldUOp.valid <= 1'b0;
        ldSrc       <= '0;
      end
    end else if (flush && ldSrc == SRC_BITS'(LD_SRC_AGU)) begin
      ldUOp.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/load_port_arbiter.sv
// ---------------------------------------------------------------------------
// load_port_arbiter
//   Per-load-port arbiter feeding the LSU load pipeline from the AGU and
//   NUM_EXT external load sources. Each port is an independent
//   load_port_arb_slot; there is no state shared between ports.
// Ports
//   clk, rst         clock, async active-high reset
//   IN_flush         kill buffered/incoming AGU ops on every port
//   IN_aguLd[p]      AGU load request;        OUT_aguLdStall[p]  : hold it
//   IN_extLd[p][k]   external load request;   OUT_extLdStall[p][k]: hold it
//   IN_ldUOpStall[p] pipeline cannot take OUT_ldUOp[p]
//   OUT_ldUOp[p]     registered load op
//   OUT_ldSrc[p]     0 = AGU, k+1 = external source k
// ---------------------------------------------------------------------------
module load_port_arbiter
  import load_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_AGUS,
  parameter int NUM_EXT    = 2,
  parameter int RR_EXT     = 1,
  parameter int STARVE_LIM = 7,
  localparam int SRC_BITS  = $clog2(NUM_EXT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_flush,
  input  LD_UOp                IN_aguLd       [NUM_PORTS],
  output logic [NUM_PORTS-1:0] OUT_aguLdStall,
  input  PW_LD_UOp             IN_extLd       [NUM_PORTS][NUM_EXT],
  output logic [NUM_EXT-1:0]   OUT_extLdStall [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] IN_ldUOpStall,
  output LD_UOp                OUT_ldUOp      [NUM_PORTS],
  output logic [SRC_BITS-1:0]  OUT_ldSrc      [NUM_PORTS]
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    load_port_arb_slot #(
      .NUM_EXT    (NUM_EXT),
      .RR_EXT     (RR_EXT),
      .STARVE_LIM (STARVE_LIM)
    ) slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (IN_flush),
      .aguLd      (IN_aguLd[p]),
      .aguLdStall (OUT_aguLdStall[p]),
      .extLd      (IN_extLd[p]),
      .extLdStall (OUT_extLdStall[p]),
      .ldUOpStall (IN_ldUOpStall[p]),
      .ldUOp      (OUT_ldUOp[p]),
      .ldSrc      (OUT_ldSrc[p])
    );
  end

endmodule

// File: tb/tb_load_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_load_port_arbiter
//   Self-checking bench for load_port_arbiter. Stimulus is applied on the
//   falling edge; a reference model predicts stalls and the ops each port
//   must deliver, pushing expected ops into per-port queues. A separate
//   monitor pops and compares whenever a port hands an op to the pipeline.
// ---------------------------------------------------------------------------
module tb_load_port_arbiter;
  import load_port_arbiter_pkg::*;

  localparam int NP  = NUM_AGUS;
  localparam int NE  = 2;
  localparam int LIM = 7;

  logic             clk;
  logic             rst;
  logic             flush;
  LD_UOp            aguLd    [NP];
  logic [NP-1:0]    aguStall;
  PW_LD_UOp         extLd    [NP][NE];
  logic [NE-1:0]    extStall [NP];
  logic [NP-1:0]    ldStall;
  LD_UOp            ldUOp    [NP];
  logic [SRC_W-1:0] ldSrc    [NP];

  load_port_arbiter #(
    .NUM_PORTS  (NP),
    .NUM_EXT    (NE),
    .RR_EXT     (1),
    .STARVE_LIM (LIM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_flush       (flush),
    .IN_aguLd       (aguLd),
    .OUT_aguLdStall (aguStall),
    .IN_extLd       (extLd),
    .OUT_extLdStall (extStall),
    .IN_ldUOpStall  (ldStall),
    .OUT_ldUOp      (ldUOp),
    .OUT_ldSrc      (ldSrc)
  );

  typedef struct {
    LD_UOp op;
    int    src;
  } expT;

  int       checks = 0;
  int       errors = 0;

  // Planned inputs for the next cycle
  LD_UOp    pAgu  [NP];
  PW_LD_UOp pExt  [NP][NE];
  bit       pStall[NP];
  bit       pFlush;

  // Reference model state
  expT      expQ   [NP][$];
  int       mAge   [NP];
  int       mPtr   [NP];
  int       mSrc   [NP];
  bit       mValid [NP];
  bit       holdAgu[NP];
  bit       holdExt[NP][NE];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic LD_UOp extOp(input logic [31:0] a);
    LD_UOp o;
    o             = '0;
    o.addr        = a;
    o.size        = 2'd2;
    o.tagDst      = TAG_ZERO;
    o.doNotCommit = 1'b1;
    o.external    = 1'b1;
    o.valid       = 1'b1;
    return o;
  endfunction

  function automatic LD_UOp randAgu();
    logic [127:0] r;
    LD_UOp o;
    r = {$urandom, $urandom, $urandom, $urandom};
    o = r[$bits(LD_UOp)-1:0];
    o.valid = 1'b1;
    return o;
  endfunction

  task automatic clearPlan();
    pFlush = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pAgu[p]   = '0;
      pStall[p] = 1'b0;
      for (int k = 0; k < NE; k++) pExt[p][k] = '0;
    end
  endtask

  task automatic clearModel();
    for (int p = 0; p < NP; p++) begin
      expQ[p].delete();
      mAge[p]    = 0;
      mPtr[p]    = 0;
      mSrc[p]    = 0;
      mValid[p]  = 1'b0;
      holdAgu[p] = 1'b0;
      for (int k = 0; k < NE; k++) holdExt[p][k] = 1'b0;
    end
  endtask

  task automatic driveIdle();
    flush = 1'b0;
    for (int p = 0; p < NP; p++) begin
      aguLd[p]   = '0;
      ldStall[p] = 1'b0;
      for (int k = 0; k < NE; k++) extLd[p][k] = '0;
    end
  endtask

  // One clock of the reference behaviour: who wins, who must hold, and what
  // the slot will hold after the coming rising edge.
  task automatic modelStep();
    for (int p = 0; p < NP; p++) begin
      bit          ldEn;
      bit          aguOk;
      int          win;
      bit          expAgu;
      logic [NE-1:0] expExt;
      expT         e;
      ldEn  = !mValid[p] || !ldStall[p];
      aguOk = aguLd[p].valid && !flush;
      win   = -1;
      if (ldEn) begin
        if (mAge[p] == LIM && aguOk) win = 0;
        else begin
          for (int i = 0; i < NE; i++) begin
            int k;
            k = (mPtr[p] + i) % NE;
            if (win < 0 && extLd[p][k].valid) win = k + 1;
          end
          if (win < 0 && aguOk) win = 0;
        end
      end
      expAgu = aguOk && (win != 0);
      for (int k = 0; k < NE; k++) expExt[k] = extLd[p][k].valid && (win != k + 1);
      checkOutput("aguStall", 128'(aguStall[p]), 128'(expAgu));
      checkOutput("extStall", 128'(extStall[p]), 128'(expExt));
      holdAgu[p] = expAgu;
      for (int k = 0; k < NE; k++) holdExt[p][k] = expExt[k];
      if (flush || win == 0) mAge[p] = 0;
      else if (win > 0 && aguLd[p].valid && mAge[p] < LIM) mAge[p] = mAge[p] + 1;
      if (win > 0) mPtr[p] = win % NE;
      if (ldEn) begin
        if (win >= 0) begin
          e.src = win;
          e.op  = (win == 0) ? aguLd[p] : extOp(extLd[p][win-1].addr);
          expQ[p].push_back(e);
          mValid[p] = 1'b1;
          mSrc[p]   = win;
        end else begin
          mValid[p] = 1'b0;
        end
      end else if (flush && mSrc[p] == 0) begin
        mValid[p] = 1'b0;
        if (expQ[p].size() > 0) void'(expQ[p].pop_front());
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    flush = pFlush;
    for (int p = 0; p < NP; p++) begin
      aguLd[p]   = pAgu[p];
      ldStall[p] = pStall[p];
      for (int k = 0; k < NE; k++) extLd[p][k] = pExt[p][k];
    end
    #1;
    modelStep();
  endtask

  task automatic fillRandom();
    for (int p = 0; p < NP; p++) begin
      if (!holdAgu[p]) pAgu[p] = ($urandom_range(0, 1) == 1) ? randAgu() : '0;
      for (int k = 0; k < NE; k++) begin
        if (!holdExt[p][k]) begin
          pExt[p][k].valid = ($urandom_range(0, 2) == 0);
          pExt[p][k].addr  = $urandom;
        end
      end
      pStall[p] = ($urandom_range(0, 3) == 0);
    end
    pFlush = ($urandom_range(0, 15) == 0);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    driveIdle();
    clearPlan();
    clearModel();
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: whenever a port hands its slot to the pipeline, compare it with
  // the oldest expected op for that port.
  initial begin : monitor
    expT   e;
    LD_UOp a;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int p = 0; p < NP; p++) begin
          if (ldUOp[p].valid && !ldStall[p]) begin
            if (expQ[p].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected op on port %0d: got valid op, required none", p);
            end else begin
              e = expQ[p].pop_front();
              a = ldUOp[p];
              if (e.src != 0) begin
                a.data    = '0;
                e.op.data = '0;
              end
              checkOutput("slot op", 128'(a), 128'(e.op));
              checkOutput("slot src", 128'(ldSrc[p]), 128'(e.src));
            end
          end
        end
      end
    end
  end

  initial begin
    doReset();

    // Reset state
    for (int p = 0; p < NP; p++) begin
      checkOutput("reset valid", 128'(ldUOp[p].valid), 128'(0));
      checkOutput("reset src", 128'(ldSrc[p]), 128'(0));
    end
    applyStimulus();

    // Single external request goes straight through
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_1234;
    applyStimulus();
    checkOutput("t1 extStall0", 128'(extStall[0][0]), 128'(0));
    afterEdge();
    checkOutput("t1 valid", 128'(ldUOp[0].valid), 128'(1));
    checkOutput("t1 external", 128'(ldUOp[0].external), 128'(1));
    checkOutput("t1 size", 128'(ldUOp[0].size), 128'(2));
    checkOutput("t1 src", 128'(ldSrc[0]), 128'(1));
    clearPlan();
    applyStimulus();

    // AGU starvation limit
    doReset();
    pAgu[0]          = randAgu();
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_2000;
    for (int i = 0; i < 9; i++) begin
      applyStimulus();
      checkOutput("t2 aguStall", 128'(aguStall[0]), 128'(i != LIM));
    end
    clearPlan();
    applyStimulus();

    // Round-robin between two external sources
    doReset();
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_3000;
    pExt[0][1].valid = 1'b1;
    pExt[0][1].addr  = 32'h0000_3100;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      afterEdge();
      checkOutput("t3 src", 128'(ldSrc[0]), 128'((i % 2) + 1));
    end
    clearPlan();
    applyStimulus();

    // Pipeline back-pressure holds the slot and stalls every requester
    doReset();
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_4000;
    applyStimulus();
    pAgu[0]          = randAgu();
    pExt[0][1].valid = 1'b1;
    pExt[0][1].addr  = 32'h0000_4100;
    pStall[0]        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("t4 aguStall", 128'(aguStall[0]), 128'(1));
      checkOutput("t4 extStall", 128'(extStall[0]), 128'(2'b11));
      afterEdge();
      checkOutput("t4 held valid", 128'(ldUOp[0].valid), 128'(1));
      checkOutput("t4 held src", 128'(ldSrc[0]), 128'(1));
    end
    pStall[0] = 1'b0;
    repeat (10) applyStimulus();
    clearPlan();
    applyStimulus();

    // Flush removes an AGU op from a stalled slot but keeps an external op
    doReset();
    pAgu[0] = randAgu();
    applyStimulus();
    clearPlan();
    pStall[0] = 1'b1;
    pFlush    = 1'b1;
    applyStimulus();
    afterEdge();
    checkOutput("t5 agu flushed", 128'(ldUOp[0].valid), 128'(0));
    clearPlan();
    applyStimulus();
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_5000;
    applyStimulus();
    clearPlan();
    pStall[0] = 1'b1;
    pFlush    = 1'b1;
    applyStimulus();
    afterEdge();
    checkOutput("t5 ext kept", 128'(ldUOp[0].valid), 128'(1));
    clearPlan();
    applyStimulus();

    // Asynchronous reset in the middle of traffic
    pExt[0][0].valid = 1'b1;
    pExt[0][0].addr  = 32'h0000_6000;
    applyStimulus();
    afterEdge();
    checkOutput("t6 before reset", 128'(ldUOp[0].valid), 128'(1));
    rst = 1'b1;
    #1;
    for (int p = 0; p < NP; p++) checkOutput("t6 async reset", 128'(ldUOp[p].valid), 128'(0));
    driveIdle();
    clearPlan();
    clearModel();
    @(negedge clk);
    #3;
    rst = 1'b0;

    // Random traffic on all ports
    for (int c = 0; c < 3000; c++) begin
      fillRandom();
      applyStimulus();
    end

    // Drain and confirm nothing is left outstanding
    clearPlan();
    repeat (6) applyStimulus();
    for (int p = 0; p < NP; p++) begin
      checkOutput("drain queue", 128'(expQ[p].size()), 128'(0));
      checkOutput("drain valid", 128'(ldUOp[p].valid), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
